// File: rtl/hdmi_text_axi_regfile.sv
// hdmi_text_axi_regfile: AXI4-Lite register file holding text VRAM words plus a control word,
// with a registered video-side read port.
module hdmi_text_axi_regfile #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int VRAM_WORDS = 600
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  input  logic [2:0]                    axi_awprot,
  input  logic                          axi_awvalid,
  output logic                          axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]   axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  input  logic                          axi_wvalid,
  output logic                          axi_wready,
  output logic [1:0]                    axi_bresp,
  output logic                          axi_bvalid,
  input  logic                          axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]   axi_araddr,
  input  logic [2:0]                    axi_arprot,
  input  logic                          axi_arvalid,
  output logic                          axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]   axi_rdata,
  output logic [1:0]                    axi_rresp,
  output logic                          axi_rvalid,
  input  logic                          axi_rready,
  input  logic [9:0]                    vid_word_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]   vid_word_data,
  output logic [C_AXI_DATA_WIDTH-1:0]   ctrl_reg
);
  localparam int IW = $clog2(VRAM_WORDS + 1);
  localparam int XW = C_AXI_ADDR_WIDTH - 2;
  localparam int SW = C_AXI_DATA_WIDTH / 8;
  localparam logic [XW-1:0] CTRL_IDX = XW'(VRAM_WORDS);
  localparam logic [IW-1:0] LAST_VRAM = IW'(VRAM_WORDS - 1);

  logic [C_AXI_DATA_WIDTH-1:0] mem [0:VRAM_WORDS];
  logic                        aw_full, w_full, ar_pend;
  logic [XW-1:0]               aw_idx, ar_idx;
  logic [C_AXI_DATA_WIDTH-1:0] w_data;
  logic [SW-1:0]               w_strb;
  logic                        commit, aw_ok, ar_ok;
  logic                        unused_bits;

  assign commit      = aw_full && w_full;
  assign aw_ok       = aw_idx <= CTRL_IDX;
  assign ar_ok       = ar_idx <= CTRL_IDX;
  assign ctrl_reg    = mem[VRAM_WORDS];
  assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      for (int i = 0; i <= VRAM_WORDS; i++) mem[i] <= '0;
    end else if (commit && aw_ok) begin
      for (int k = 0; k < SW; k++)
        if (w_strb[k]) mem[aw_idx[IW-1:0]][8*k +: 8] <= w_data[8*k +: 8];
    end
  end

  // Ready pulses are gated by their own previous value so each handshake is exactly one cycle.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      axi_awready   <= 1'b0;
      axi_wready    <= 1'b0;
      axi_bvalid    <= 1'b0;
      axi_bresp     <= 2'b00;
      axi_arready   <= 1'b0;
      axi_rvalid    <= 1'b0;
      axi_rresp     <= 2'b00;
      axi_rdata     <= '0;
      vid_word_data <= '0;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_pend       <= 1'b0;
      aw_idx        <= '0;
      ar_idx        <= '0;
      w_data        <= '0;
      w_strb        <= '0;
    end else begin
      axi_awready <= axi_awvalid && !axi_awready && !aw_full && !axi_bvalid;
      axi_wready  <= axi_wvalid && !axi_wready && !w_full && !axi_bvalid;
      if (axi_awvalid && axi_awready) begin
        aw_full <= 1'b1;
        aw_idx  <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
      end
      if (axi_wvalid && axi_wready) begin
        w_full <= 1'b1;
        w_data <= axi_wdata;
        w_strb <= axi_wstrb;
      end
      if (commit) begin
        aw_full    <= 1'b0;
        w_full     <= 1'b0;
        axi_bvalid <= 1'b1;
        axi_bresp  <= aw_ok ? 2'b00 : 2'b10;
      end else if (axi_bvalid && axi_bready) begin
        axi_bvalid <= 1'b0;
      end
      axi_arready <= axi_arvalid && !axi_arready && !ar_pend && !axi_rvalid;
      if (axi_arvalid && axi_arready) begin
        ar_pend <= 1'b1;
        ar_idx  <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
      end
      if (ar_pend) begin
        ar_pend    <= 1'b0;
        axi_rvalid <= 1'b1;
        axi_rdata  <= ar_ok ? mem[ar_idx[IW-1:0]] : '0;
        axi_rresp  <= ar_ok ? 2'b00 : 2'b10;
      end else if (axi_rvalid && axi_rready) begin
        axi_rvalid <= 1'b0;
      end
      vid_word_data <= (vid_word_addr <= LAST_VRAM) ? mem[vid_word_addr] : '0;
    end
  end
endmodule

// File: tb/tb_hdmi_text_axi_regfile.sv
// tb_hdmi_text_axi_regfile: directed self-checking bench for the HDMI text AXI register file.
module tb_hdmi_text_axi_regfile;
  logic        axi_aclk = 1'b0;
  logic        axi_aresetn;
  logic [15:0] axi_awaddr, axi_araddr;
  logic [2:0]  axi_awprot, axi_arprot;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [31:0] axi_wdata, axi_rdata;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [9:0]  vid_word_addr;
  logic [31:0] vid_word_data, ctrl_reg;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [0:600];

  always #5 axi_aclk = ~axi_aclk;

  hdmi_text_axi_regfile dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .vid_word_addr(vid_word_addr), .vid_word_data(vid_word_data), .ctrl_reg(ctrl_reg)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 0;
    bit w_done = 0;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    for (int n = 0; n < 50 && !(aw_done && w_done); n++) begin
      @(negedge axi_aclk);
      if (axi_awready) aw_done = 1;
      if (axi_wready) w_done = 1;
      @(posedge axi_aclk); #1;
      if (aw_done) axi_awvalid = 1'b0;
      if (w_done) axi_wvalid = 1'b0;
    end
    for (int n = 0; n < 50; n++) begin
      @(negedge axi_aclk);
      if (axi_bvalid) break;
    end
    chk("wr_bvalid_timeout", 32'(axi_bvalid), 1);
    resp = axi_bresp;
    @(posedge axi_aclk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r,
                          output int pulses);
    pulses = 0;
    axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge axi_aclk);
      if (axi_arready) pulses++;
      if (axi_rvalid) break;
      @(posedge axi_aclk); #1;
      if (pulses > 0) axi_arvalid = 1'b0;
    end
    chk("rd_rvalid_timeout", 32'(axi_rvalid), 1);
    d = axi_rdata; r = axi_rresp;
    @(posedge axi_aclk); #1;
    axi_arvalid = 1'b0; axi_rready = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [15:0] a, input logic [31:0] exp_d,
                          input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    int          p;
    axi_read(a, d, r, p);
    chk({tag, "_data"}, d, exp_d);
    chk({tag, "_resp"}, 32'(r), 32'(exp_r));
    chk({tag, "_arpulse"}, 32'(p), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [1:0] resp;
    int wp, ap;
    bit seen;
    axi_aresetn = 1'b0;
    axi_awaddr = '0; axi_araddr = '0; axi_awprot = '0; axi_arprot = '0;
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; axi_bready = 0; axi_rready = 0;
    axi_wdata = '0; axi_wstrb = '0; vid_word_addr = '0;
    for (int i = 0; i < 600; i++) model[i] = 32'(i);
    model[600] = 32'h001F6000;

    repeat (3) @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("rst_awready", 32'(axi_awready), 0);
    chk("rst_wready", 32'(axi_wready), 0);
    chk("rst_bvalid", 32'(axi_bvalid), 0);
    chk("rst_arready", 32'(axi_arready), 0);
    chk("rst_rvalid", 32'(axi_rvalid), 0);
    chk("rst_bresp", 32'(axi_bresp), 0);
    chk("rst_rresp", 32'(axi_rresp), 0);
    chk("rst_rdata", axi_rdata, 0);
    chk("rst_vid", vid_word_data, 0);
    chk("rst_ctrl", ctrl_reg, 0);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;

    // Minimum-latency write to the control register, AW and W together.
    axi_awaddr = 16'h0960; axi_wdata = 32'h001F6000; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b0;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("lat_awready_hi", 32'(axi_awready), 1);
    chk("lat_wready_hi", 32'(axi_wready), 1);
    chk("lat_bvalid_c1", 32'(axi_bvalid), 0);
    @(posedge axi_aclk); #1;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    @(negedge axi_aclk);
    chk("lat_awready_lo", 32'(axi_awready), 0);
    chk("lat_wready_lo", 32'(axi_wready), 0);
    chk("lat_bvalid_c2", 32'(axi_bvalid), 0);
    @(negedge axi_aclk);
    chk("lat_bvalid_e2", 32'(axi_bvalid), 1);
    chk("lat_bresp", 32'(axi_bresp), 0);
    chk("lat_ctrl", ctrl_reg, 32'h001F6000);
    @(posedge axi_aclk); #1;
    axi_bready = 1'b1;
    @(posedge axi_aclk); #1;
    axi_bready = 1'b0;
    @(negedge axi_aclk);
    chk("lat_bvalid_clr", 32'(axi_bvalid), 0);
    @(posedge axi_aclk); #1;
    read_chk("ctrl_rd", 16'h0960, 32'h001F6000, 2'b00);

    // Fill all VRAM words with their index, then read back.
    for (int i = 0; i < 600; i++) begin
      axi_write(16'(i * 4), 32'(i), 4'hF, resp);
      chk($sformatf("fill_bresp%0d", i), 32'(resp), 0);
    end
    for (int i = 0; i < 600; i++) read_chk($sformatf("fill_rd%0d", i), 16'(i * 4), 32'(i), 2'b00);

    vid_word_addr = 10'd37;
    @(posedge axi_aclk);
    @(negedge axi_aclk);
    chk("vid_37", vid_word_data, 37);
    vid_word_addr = 10'd599;
    @(negedge axi_aclk);
    chk("vid_599", vid_word_data, 599);
    vid_word_addr = 10'd600;
    @(negedge axi_aclk);
    chk("vid_600_zero", vid_word_data, 0);
    @(posedge axi_aclk); #1;

    // Byte-lane strobes on word 4.
    axi_write(16'h0010, 32'hAABBCCDD, 4'hF, resp);
    axi_write(16'h0010, 32'h11223344, 4'b0010, resp);
    read_chk("strb_b1", 16'h0010, 32'hAABB33DD, 2'b00);
    axi_write(16'h0010, 32'h55660000, 4'b1100, resp);
    read_chk("strb_hi", 16'h0010, 32'h556633DD, 2'b00);
    model[4] = 32'h556633DD;

    // W leads AW; second AW must stall while the response is pending.
    wp = 0; ap = 0;
    axi_wdata = 32'hCAFEF00D; axi_wstrb = 4'hF; axi_wvalid = 1'b1; axi_awvalid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge axi_aclk);
      if (axi_wready) wp++;
      chk($sformatf("wlead_nob%0d", c), 32'(axi_bvalid), 0);
      @(posedge axi_aclk); #1;
      if (wp > 0) axi_wvalid = 1'b0;
    end
    chk("wlead_wpulse", 32'(wp), 1);
    axi_awaddr = 16'h0020; axi_awvalid = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge axi_aclk);
      if (axi_awready) ap++;
      if (axi_bvalid) break;
      @(posedge axi_aclk); #1;
      if (ap > 0) axi_awvalid = 1'b0;
    end
    chk("wlead_bvalid", 32'(axi_bvalid), 1);
    chk("wlead_apulse", 32'(ap), 1);
    chk("wlead_bresp", 32'(axi_bresp), 0);
    @(posedge axi_aclk); #1;
    axi_awaddr = 16'h0024; axi_awvalid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge axi_aclk);
      chk($sformatf("wlead_aw2_blk%0d", c), 32'(axi_awready), 0);
      chk($sformatf("wlead_bhold%0d", c), 32'(axi_bvalid), 1);
    end
    @(posedge axi_aclk); #1;
    axi_awvalid = 1'b0; axi_bready = 1'b1;
    @(posedge axi_aclk); #1;
    axi_bready = 1'b0;
    @(negedge axi_aclk);
    chk("wlead_bclr", 32'(axi_bvalid), 0);
    @(posedge axi_aclk); #1;
    model[8] = 32'hCAFEF00D;
    read_chk("wlead_rd8", 16'h0020, 32'hCAFEF00D, 2'b00);
    read_chk("wlead_rd9", 16'h0024, 32'd9, 2'b00);

    // Out-of-range accesses.
    axi_write(16'h0964, 32'hDEADBEEF, 4'hF, resp);
    chk("oor_bresp", 32'(resp), 2);
    chk("oor_ctrl", ctrl_reg, model[600]);
    for (int i = 0; i <= 600; i++) read_chk($sformatf("oor_keep%0d", i), 16'(i * 4), model[i], 2'b00);
    read_chk("oor_rd", 16'h0964, 32'h0, 2'b10);

    // Read backpressure.
    seen = 0;
    axi_araddr = 16'h0010; axi_arvalid = 1'b1; axi_rready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge axi_aclk);
      if (axi_arready) seen = 1;
      if (axi_rvalid) break;
      @(posedge axi_aclk); #1;
      if (seen) axi_arvalid = 1'b0;
    end
    chk("bp_rvalid", 32'(axi_rvalid), 1);
    @(posedge axi_aclk); #1;
    axi_araddr = 16'h0020; axi_arvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge axi_aclk);
      chk($sformatf("bp_rvalid%0d", c), 32'(axi_rvalid), 1);
      chk($sformatf("bp_rdata%0d", c), axi_rdata, 32'h556633DD);
      chk($sformatf("bp_arready%0d", c), 32'(axi_arready), 0);
    end
    @(posedge axi_aclk); #1;
    axi_rready = 1'b1; axi_arvalid = 1'b0;
    @(posedge axi_aclk); #1;
    axi_rready = 1'b0;
    @(negedge axi_aclk);
    chk("bp_rvalid_clr", 32'(axi_rvalid), 0);
    @(posedge axi_aclk); #1;

    // Asynchronous reset while a write response is pending.
    wp = 0; ap = 0;
    axi_awaddr = 16'h0960; axi_wdata = 32'h12345678; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge axi_aclk);
      if (axi_awready) ap++;
      if (axi_wready) wp++;
      if (axi_bvalid) break;
      @(posedge axi_aclk); #1;
      if (ap > 0) axi_awvalid = 1'b0;
      if (wp > 0) axi_wvalid = 1'b0;
    end
    chk("rstb_bvalid", 32'(axi_bvalid), 1);
    chk("rstb_ctrl_pre", ctrl_reg, 32'h12345678);
    #2;
    axi_aresetn = 1'b0;
    #1;
    chk("rstb_bvalid_async", 32'(axi_bvalid), 0);
    chk("rstb_ctrl_async", ctrl_reg, 0);
    @(posedge axi_aclk); #1;
    axi_aresetn = 1'b1;
    @(posedge axi_aclk); #1;
    read_chk("rstb_ctrl_rd", 16'h0960, 32'h0, 2'b00);
    read_chk("rstb_vram_rd", 16'h0010, 32'h0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
